hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage MIPS core. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC enable.
- Resolves data-memory waits, taken branches/jumps, load-use hazards and halt drain with fixed priority.
- Keeps a halt-sequencing FSM and two saturating performance counters.
- Pipeline registers update only when stall=0 and ihit=1, and clear on flush&ihit. Every control here is a level held until ihit consumes it.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

    // Halt sequencing: normal issue, draining older work behind a halt, stopped.
    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_t;

    // Per pipeline-register control pair.
    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    // Count up on inc, hold once all-ones is reached so the value never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush of the four pipeline registers,
// PC enable, halt drain FSM and two saturating performance counters.
//
// state   | meaning
// RUN     | normal issue; mem wait > redirect > load-use > none
// DRAIN   | halt seen in EX; block younger fetches until halt reaches WB
// HALTED  | pipeline frozen, halted=1; only reset leaves
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_RW,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ex_redirect,
    input  logic             idex_halt,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_stall,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t  r_state;
    logic       w_mem_busy;
    logic       w_load_use;
    logic       w_pc_en;
    logic       w_halted;
    pipe_ctrl_t w_ifid, w_idex, w_exmem, w_memwb;
    logic       w_stall_inc;
    logic       w_flush_inc;

    assign w_mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign w_load_use = idex_dREN & (idex_RW != REG_ZERO) &
                        ((idex_RW == ifid_rs) | (ifid_uses_rt & (idex_RW == ifid_rt)));

    // Control outputs decoded from state and live hazards; exactly one category wins.
    always_comb begin
        w_pc_en  = 1'b1;
        w_halted = 1'b0;
        w_ifid   = '0;
        w_idex   = '0;
        w_exmem  = '0;
        w_memwb  = '0;
        case (r_state)
            HZ_HALTED: begin
                w_pc_en       = 1'b0;
                w_ifid.stall  = 1'b1;
                w_idex.stall  = 1'b1;
                w_exmem.stall = 1'b1;
                w_memwb.stall = 1'b1;
                w_halted      = 1'b1;
            end
            HZ_DRAIN: begin
                w_pc_en = 1'b0;
                if (w_mem_busy) begin
                    w_ifid.stall  = 1'b1;
                    w_idex.stall  = 1'b1;
                    w_exmem.stall = 1'b1;
                    w_memwb.flush = 1'b1;
                end else begin
                    w_ifid.flush = 1'b1;
                end
            end
            default: begin
                if (w_mem_busy) begin
                    w_pc_en       = 1'b0;
                    w_ifid.stall  = 1'b1;
                    w_idex.stall  = 1'b1;
                    w_exmem.stall = 1'b1;
                    w_memwb.flush = 1'b1;
                end else if (ex_redirect) begin
                    w_ifid.flush = 1'b1;
                    w_idex.flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_en      = 1'b0;
                    w_ifid.stall = 1'b1;
                    w_idex.flush = 1'b1;
                end
            end
        endcase
    end

    // Halt sequencing: enter DRAIN only when the halt is actually consumed in EX.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= HZ_RUN;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (idex_halt && ihit && !w_mem_busy && !ex_redirect)
                        r_state <= HZ_DRAIN;
                end
                HZ_DRAIN: begin
                    if (memwb_halt)
                        r_state <= HZ_HALTED;
                end
                HZ_HALTED: r_state <= HZ_HALTED;
                default:   r_state <= HZ_RUN;
            endcase
        end
    end

    // Stall cycles count regardless of ihit; flushes count only when consumed.
    assign w_stall_inc = (r_state != HZ_HALTED) & ~w_pc_en;
    assign w_flush_inc = (r_state == HZ_RUN) & ex_redirect & ihit & ~w_mem_busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (w_stall_inc),
        .clr   (1'b0),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (w_flush_inc),
        .clr   (1'b0),
        .value (flush_cnt)
    );

    assign pc_en       = w_pc_en;
    assign halted      = w_halted;
    assign ifid_stall  = w_ifid.stall;
    assign ifid_flush  = w_ifid.flush;
    assign idex_stall  = w_idex.stall;
    assign idex_flush  = w_idex.flush;
    assign exmem_stall = w_exmem.stall;
    assign exmem_flush = w_exmem.flush;
    assign memwb_stall = w_memwb.stall;
    assign memwb_flush = w_memwb.flush;

endmodule
